cursor_step_ctrl: RTL

- Two-axis (X/Y) cursor position controller for the VDC path.
- Replaces the single-axis up/down counter.
- Steps one or both axes on a fire edge. Adds hold-to-repeat auto-stepping, configurable axis limits, and wrap or saturate at the limits.
- Registered positions feed the VDC vector decode downstream.

---
 rtl/cursor_step_ctrl_pkg.sv | 11 +
 rtl/cursor_step_ctrl_axis.sv | 26 ++
 rtl/cursor_step_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/cursor_step_ctrl_pkg.sv
// cursor_pkg: shared FSM state type, step-direction encoding and default parameters for cursor_step_ctrl
package cursor_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;
  localparam int DEF_W = 2;
  localparam int DEF_MAX_X = 3;
  localparam int DEF_MAX_Y = 3;
  localparam int DEF_REPEAT_DLY = 8;
  localparam int DEF_REPEAT_RATE = 4;
endpackage

// File: rtl/cursor_step_ctrl_axis.sv
// cursor_axis: one cursor axis; clamped load in rst, wrap/saturate step, blocked flag (clk, rst, en, dec, wrap, load -> pos, blocked)
module cursor_axis import cursor_pkg::*; #(
  parameter int W = DEF_W,
  parameter int MAX = DEF_MAX_X
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dec,
  input  logic         wrap,
  input  logic [W-1:0] load,
  output logic [W-1:0] pos,
  output logic         blocked
);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  logic         at_edge;
  logic [W-1:0] nxt;
  always_comb begin
    at_edge = (dec == DIR_DEC) ? (pos == '0) : (pos == MAX_V);
    nxt     = at_edge ? (wrap ? ((dec == DIR_DEC) ? MAX_V : '0) : pos)
                      : ((dec == DIR_DEC) ? pos - 1'b1 : pos + 1'b1);
    blocked = en & at_edge & ~wrap;
  end
  always_ff @(posedge clk)
    pos <= rst ? ((load > MAX_V) ? MAX_V : load) : (en ? nxt : pos);
endmodule

// File: rtl/cursor_step_ctrl.sv
// cursor_step_ctrl: two-axis cursor with fire-edge stepping, hold-to-repeat, wrap/saturate limits; optional one-hot outputs under CURSOR_ONEHOT_OUT_EN (clk, rst, fire, sel_x/y, dec, wrap_mode, load_x/y -> pos_x/y, step_pulse, at_limit[, pos_x_oh, pos_y_oh])
module cursor_step_ctrl import cursor_pkg::*; #(
  parameter int W = DEF_W,
  parameter int MAX_X = DEF_MAX_X,
  parameter int MAX_Y = DEF_MAX_Y,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fire,
  input  logic         sel_x,
  input  logic         sel_y,
  input  logic         dec,
  input  logic         wrap_mode,
  input  logic [W-1:0] load_x,
  input  logic [W-1:0] load_y,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic         step_pulse,
  output logic         at_limit
`ifdef CURSOR_ONEHOT_OUT_EN
  ,
  output logic [MAX_X:0] pos_x_oh,
  output logic [MAX_Y:0] pos_y_oh
`endif
);
  localparam int TW = $clog2(REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE) + 1;
  state_t        state;
  logic [TW-1:0] timer;
  logic          fire_ff;
  logic          req;
  logic          step;
  logic          blk_x;
  logic          blk_y;
  always_comb begin
    req  = (state == IDLE) ? (fire & ~fire_ff)
         : (state == HOLD) ? (fire && timer == TW'(REPEAT_DLY))
         : (fire && timer == TW'(REPEAT_RATE));
    step = req & (sel_x | sel_y);
  end
  // fire_ff resets high so a fire held through reset release is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      fire_ff    <= 1'b1;
      step_pulse <= 1'b0;
      at_limit   <= 1'b0;
    end else begin
      fire_ff    <= fire;
      step_pulse <= step;
      at_limit   <= blk_x | blk_y;
      case (state)
        IDLE: if (req) begin
          state <= HOLD;
          timer <= TW'(1);
        end
        HOLD, REPEAT: if (!fire) begin
          state <= IDLE;
          timer <= '0;
        end else if (req) begin
          state <= REPEAT;
          timer <= TW'(1);
        end else timer <= timer + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  cursor_axis #(.W(W), .MAX(MAX_X)) u_x (
    .clk(clk), .rst(rst), .en(step & sel_x), .dec(dec), .wrap(wrap_mode),
    .load(load_x), .pos(pos_x), .blocked(blk_x)
  );
  cursor_axis #(.W(W), .MAX(MAX_Y)) u_y (
    .clk(clk), .rst(rst), .en(step & sel_y), .dec(dec), .wrap(wrap_mode),
    .load(load_y), .pos(pos_y), .blocked(blk_y)
  );
`ifdef CURSOR_ONEHOT_OUT_EN
  assign pos_x_oh = {{MAX_X{1'b0}}, 1'b1} << pos_x;
  assign pos_y_oh = {{MAX_Y{1'b0}}, 1'b1} << pos_y;
`endif
endmodule
